// File: rtl/led_sequencer.sv
// Multi-channel LED sequencer: per-channel OFF / ON / BLINK / BURST modes
// driven from a shared millisecond-style tick prescaler.
module led_sequencer #(
    parameter int NUM_LEDS   = 4,
    parameter int TICK_LIMIT = 49999,
    parameter int CNT_W      = 16,
    localparam int CH_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cfg_valid,
    input  logic [CH_W-1:0]     i_cfg_ch,
    input  logic [1:0]          i_cfg_mode,
    input  logic [CNT_W-1:0]    i_cfg_period,
    input  logic [7:0]          i_cfg_count,
    output logic                o_cfg_ready,
    output logic [NUM_LEDS-1:0] o_led,
    output logic [NUM_LEDS-1:0] o_busy
);

    localparam int PW = (TICK_LIMIT > 0) ? $clog2(TICK_LIMIT + 1) : 1;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    logic [PW-1:0]       presc_q, presc_d;
    logic                tick;
    logic                ready_q;
    logic                wr_en;

    logic [1:0]          mode_q   [NUM_LEDS];
    logic [1:0]          mode_d   [NUM_LEDS];
    logic [CNT_W-1:0]    period_q [NUM_LEDS];
    logic [CNT_W-1:0]    period_d [NUM_LEDS];
    logic [CNT_W-1:0]    phase_q  [NUM_LEDS];
    logic [CNT_W-1:0]    phase_d  [NUM_LEDS];
    logic [7:0]          count_q  [NUM_LEDS];
    logic [7:0]          count_d  [NUM_LEDS];
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [NUM_LEDS-1:0] busy_q, busy_d;

    assign tick    = (presc_q == PW'(TICK_LIMIT));
    assign presc_d = tick ? '0 : presc_q + PW'(1);
    assign wr_en   = i_cfg_valid && ready_q;

    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        phase_d  = phase_q;
        count_d  = count_q;
        led_d    = led_q;
        busy_d   = busy_q;
        for (int n = 0; n < NUM_LEDS; n++) begin
            if (tick && (mode_q[n] == MODE_BLINK || mode_q[n] == MODE_BURST)) begin
                if (phase_q[n] == period_q[n]) begin
                    phase_d[n] = '0;
                    led_d[n]   = ~led_q[n];
                    // Only falling toggles consume a burst pulse.
                    if (mode_q[n] == MODE_BURST && led_q[n]) begin
                        count_d[n] = count_q[n] - 8'd1;
                        if (count_q[n] == 8'd1) begin
                            mode_d[n] = MODE_OFF;
                            busy_d[n] = 1'b0;
                        end
                    end
                end else begin
                    phase_d[n] = phase_q[n] + CNT_W'(1);
                end
            end
            // A write overrides whatever the tick decided this cycle.
            if (wr_en && i_cfg_ch == CH_W'(n)) begin
                phase_d[n]  = '0;
                period_d[n] = i_cfg_period;
                count_d[n]  = i_cfg_count;
                case (i_cfg_mode)
                    MODE_ON: begin
                        mode_d[n] = MODE_ON;
                        led_d[n]  = 1'b1;
                        busy_d[n] = 1'b0;
                    end
                    MODE_BLINK: begin
                        mode_d[n] = MODE_BLINK;
                        led_d[n]  = 1'b1;
                        busy_d[n] = 1'b0;
                    end
                    MODE_BURST: begin
                        if (i_cfg_count != 8'd0) begin
                            mode_d[n] = MODE_BURST;
                            led_d[n]  = 1'b1;
                            busy_d[n] = 1'b1;
                        end else begin
                            mode_d[n] = MODE_OFF;
                            led_d[n]  = 1'b0;
                            busy_d[n] = 1'b0;
                        end
                    end
                    default: begin
                        mode_d[n] = MODE_OFF;
                        led_d[n]  = 1'b0;
                        busy_d[n] = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_q <= '0;
            ready_q <= 1'b0;
            led_q   <= '0;
            busy_q  <= '0;
            for (int n = 0; n < NUM_LEDS; n++) begin
                mode_q[n]   <= MODE_OFF;
                period_q[n] <= '0;
                phase_q[n]  <= '0;
                count_q[n]  <= '0;
            end
        end else begin
            presc_q  <= presc_d;
            ready_q  <= 1'b1;
            led_q    <= led_d;
            busy_q   <= busy_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            phase_q  <= phase_d;
            count_q  <= count_d;
        end
    end

    assign o_cfg_ready = ready_q;
    assign o_led       = led_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: table of configuration writes plus
// hand-timed BLINK / BURST / reset sequences aligned to the tick.
module tb_led_sequencer;

    localparam int N  = 3;
    localparam int TL = 9;
    localparam int CW = 8;

    localparam logic [1:0] OFF   = 2'b00;
    localparam logic [1:0] ON    = 2'b01;
    localparam logic [1:0] BLINK = 2'b10;
    localparam logic [1:0] BURST = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic [1:0]    ch = '0;
    logic [1:0]    mode = '0;
    logic [CW-1:0] per = '0;
    logic [7:0]    cnt = '0;
    logic          ready;
    logic [N-1:0]  led;
    logic [N-1:0]  busy;

    int n_vec = 0;
    int n_err = 0;
    int since = 0;

    typedef struct {
        logic         v;
        logic [1:0]   ch;
        logic [1:0]   mode;
        logic [7:0]   per;
        logic [7:0]   cnt;
        logic [N-1:0] eled;
        logic [N-1:0] ebusy;
    } vec_t;

    vec_t tbl [10];

    led_sequencer #(
        .NUM_LEDS  (N),
        .TICK_LIMIT(TL),
        .CNT_W     (CW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cfg_valid (valid),
        .i_cfg_ch    (ch),
        .i_cfg_mode  (mode),
        .i_cfg_period(per),
        .i_cfg_count (cnt),
        .o_cfg_ready (ready),
        .o_led       (led),
        .o_busy      (busy)
    );

    always #10 clk = ~clk;

    // Edges since the last reset edge; toggles land on multiples of TL+1.
    always @(posedge clk) since <= rst ? 0 : since + 1;

    task automatic chk(input string nm, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] c,
                         input logic [1:0] m, input logic [7:0] p,
                         input logic [7:0] k, input bit align);
        @(negedge clk);
        if (align)
            while (since % (TL + 1) != TL) @(negedge clk);
        valid = v;
        ch    = c;
        mode  = m;
        per   = p;
        cnt   = k;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 2'd0, BLINK, 8'd200, 8'd0, 3'b001, 3'b000};
        tbl[1] = '{1'b1, 2'd1, BURST, 8'd200, 8'd5, 3'b011, 3'b010};
        tbl[2] = '{1'b1, 2'd2, ON,    8'd0,   8'd0, 3'b111, 3'b010};
        tbl[3] = '{1'b1, 2'd3, OFF,   8'd0,   8'd0, 3'b111, 3'b010};
        tbl[4] = '{1'b1, 2'd1, BURST, 8'd200, 8'd0, 3'b101, 3'b000};
        tbl[5] = '{1'b1, 2'd0, OFF,   8'd0,   8'd0, 3'b100, 3'b000};
        tbl[6] = '{1'b0, 2'd0, ON,    8'd0,   8'd0, 3'b100, 3'b000};
        tbl[7] = '{1'b1, 2'd2, OFF,   8'd0,   8'd0, 3'b000, 3'b000};
        tbl[8] = '{1'b1, 2'd1, ON,    8'd0,   8'd0, 3'b010, 3'b000};
        tbl[9] = '{1'b1, 2'd1, OFF,   8'd0,   8'd0, 3'b000, 3'b000};

        // Reset and release
        repeat (2) @(posedge clk);
        #1;
        chk("rst_led", 0, led, 3'b000);
        chk("rst_busy", 0, busy, 3'b000);
        chk("rst_ready", 0, ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("rel_ready", 0, ready, 1'b1);
        chk("rel_led", 0, led, 3'b000);
        chk("rel_busy", 0, busy, 3'b000);

        // Table of single writes with immediate effect
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].ch, tbl[i].mode, tbl[i].per, tbl[i].cnt, 1'b0);
            chk("tbl_led", i, led, tbl[i].eled);
            chk("tbl_busy", i, busy, tbl[i].ebusy);
        end

        // BLINK ch0 period 1: 20-clock high/low intervals
        drive(1'b1, 2'd0, BLINK, 8'd1, 8'd0, 1'b1);
        for (int j = 0; j < 80; j++) begin
            if (j > 0) step();
            chk("blink_led0", j, led[0], ((j / 20) % 2) == 0);
            chk("blink_oth", j, led[2:1], 2'b00);
        end

        // BURST ch1 period 0 count 3: three 10-clock pulses then idle
        drive(1'b1, 2'd1, BURST, 8'd0, 8'd3, 1'b1);
        for (int j = 0; j < 100; j++) begin
            if (j > 0) step();
            chk("burst_led1", j, led[1], (j < 50) && ((j / 10) % 2 == 0));
            chk("burst_busy1", j, busy[1], j < 50);
            chk("burst_ch2", j, {led[2], busy[2]}, 2'b00);
        end

        // Mid-burst OFF landing on a rising toggle edge: write wins
        drive(1'b1, 2'd1, BURST, 8'd0, 8'd3, 1'b1);
        chk("mid_start", 0, {led[1], busy[1]}, 2'b11);
        repeat (12) step();
        drive(1'b1, 2'd1, OFF, 8'd0, 8'd0, 1'b1);
        chk("mid_off", 0, {led[1], busy[1]}, 2'b00);
        for (int j = 1; j <= 15; j++) begin
            step();
            chk("mid_off", j, {led[1], busy[1]}, 2'b00);
        end
        drive(1'b1, 2'd2, BURST, 8'd5, 8'd0, 1'b0);
        chk("burst_c0", 0, {led[2], busy[2]}, 2'b00);

        // Out-of-range channel is ignored; ON holds steady
        drive(1'b1, 2'd0, OFF, 8'd0, 8'd0, 1'b0);
        chk("pre_led", 0, led, 3'b000);
        drive(1'b1, 2'd1, ON, 8'd0, 8'd0, 1'b0);
        chk("pre_led", 1, led, 3'b010);
        drive(1'b1, 2'd3, BURST, 8'd0, 8'd4, 1'b0);
        chk("ch3_led", 0, led, 3'b010);
        chk("ch3_busy", 0, busy, 3'b000);
        drive(1'b1, 2'd3, ON, 8'd0, 8'd0, 1'b0);
        chk("ch3_led", 1, led, 3'b010);
        drive(1'b1, 2'd0, ON, 8'd0, 8'd0, 1'b0);
        for (int j = 0; j < 100; j++) begin
            if (j > 0) step();
            chk("on_led", j, led, 3'b011);
            chk("on_busy", j, busy, 3'b000);
        end

        // Reset during active BLINK and BURST
        drive(1'b1, 2'd0, BLINK, 8'd0, 8'd0, 1'b1);
        drive(1'b1, 2'd1, BURST, 8'd0, 8'd3, 1'b0);
        chk("act_led", 0, led, 3'b011);
        chk("act_busy", 0, busy, 3'b010);
        repeat (3) step();
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("arst_led", 0, led, 3'b000);
        chk("arst_busy", 0, busy, 3'b000);
        chk("arst_ready", 0, ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 100; j++) begin
            step();
            chk("post_led", j, led, 3'b000);
            chk("post_busy", j, busy, 3'b000);
        end
        chk("post_ready", 0, ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
